// File: rtl/dpu_pkg.sv
// rtl/dpu_pkg.sv - shared opcodes, microword fields and state/class enums for the DPU sequencer
package dpu_pkg;

  localparam int N_MSB = 15;
  localparam int N_LSB = 12;
  localparam int A_MSB = 11;
  localparam int A_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 4;
  localparam int R_MSB = 3;
  localparam int R_LSB = 0;

  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_BRCC = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_VID  = 4'd11;
  localparam logic [3:0] OP_CALL = 4'd12;
  localparam logic [3:0] OP_RET  = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_LOAD_WAIT,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_VID,
    CLS_CALL,
    CLS_RET,
    CLS_NOP,
    CLS_HALT
  } op_class_t;

endpackage

// File: rtl/dpu_seq_decode.sv
// rtl/dpu_seq_decode.sv - combinational opcode classifier for the DPU sequencer
// CALL/RET classes only exist when DPU_SEQ_CALL_RET_EN is defined; otherwise n=12/13 classify as NOP.
module dpu_seq_decode
  import dpu_pkg::*;
(
  input  logic [3:0] n_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = CLS_NOP;
    if (n_i < OP_LOAD) begin
      cls_o = CLS_ALU;
    end else begin
      case (n_i)
        OP_LOAD: cls_o = CLS_LOAD;
        OP_BRCC: cls_o = CLS_BRANCH;
        OP_JMP:  cls_o = CLS_JUMP;
        OP_VID:  cls_o = CLS_VID;
`ifdef DPU_SEQ_CALL_RET_EN
        OP_CALL: cls_o = CLS_CALL;
        OP_RET:  cls_o = CLS_RET;
`endif
        OP_HALT: cls_o = CLS_HALT;
        default: cls_o = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/dpu_sequencer.sv
// rtl/dpu_sequencer.sv - microprogram sequencer: fetches microwords and drives DPU control buses
// Optional single-level CALL/RET link register enabled by DPU_SEQ_CALL_RET_EN.
module dpu_sequencer
  import dpu_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter int              ALU_CYCLES = 2,
  parameter logic [3:0]      IDLE_OP    = 4'hE,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic [3:0]      dpu_abus,
  output logic [3:0]      dpu_bbus,
  output logic [3:0]      dpu_rbus,
  output logic [3:0]      dpu_n,
  input  logic [3:0]      dpu_cc,
  output logic            dpu_out_enable,
  output logic            busy,
  output logic            halted
);

  localparam int CNT_W = (ALU_CYCLES > 1) ? $clog2(ALU_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            vid_q, vid_d;
  logic [3:0]      ir_n_q, abus_q, bbus_q, rbus_q;
  op_class_t       op_cls;
  logic [PC_W-1:0] pc_inc, target;

  assign pc_inc = pc_q + PC_W'(1);
  // {b,r} forms an 8-bit target, resized to the PC width
  assign target = PC_W'({bbus_q, rbus_q});

`ifdef DPU_SEQ_CALL_RET_EN
  logic [PC_W-1:0] link_q, link_d;
`endif

  dpu_seq_decode u_decode (
    .n_i   (ir_n_q),
    .cls_o (op_cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      vid_q   <= 1'b0;
`ifdef DPU_SEQ_CALL_RET_EN
      link_q  <= RESET_PC;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      vid_q   <= vid_d;
`ifdef DPU_SEQ_CALL_RET_EN
      link_q  <= link_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_n_q <= OP_NOP;
      abus_q <= '0;
      bbus_q <= '0;
      rbus_q <= '0;
    end else if (state_q == ST_FETCH && imem_valid) begin
      ir_n_q <= imem_data[N_MSB:N_LSB];
      abus_q <= imem_data[A_MSB:A_LSB];
      bbus_q <= imem_data[B_MSB:B_LSB];
      rbus_q <= imem_data[R_MSB:R_LSB];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    vid_d   = vid_q;
`ifdef DPU_SEQ_CALL_RET_EN
    link_d  = link_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        cnt_d   = '0;
        state_d = ST_FETCH;
        case (op_cls)
          CLS_ALU:    state_d = ST_EXEC;
          CLS_LOAD:   state_d = ST_LOAD_WAIT;
          CLS_BRANCH: pc_d = dpu_cc[abus_q[1:0]] ? target : pc_inc;
          CLS_JUMP:   pc_d = target;
          CLS_VID: begin
            vid_d = ~vid_q;
            pc_d  = pc_inc;
          end
`ifdef DPU_SEQ_CALL_RET_EN
          CLS_CALL: begin
            link_d = pc_inc;
            pc_d   = target;
          end
          CLS_RET:    pc_d = link_q;
`endif
          CLS_HALT:   state_d = ST_HALT;
          default:    pc_d = pc_inc;
        endcase
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(ALU_CYCLES - 1)) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_ack) begin
          state_d = ST_FETCH;
          pc_d    = pc_inc;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    mem_req  = 1'b0;
    dpu_n    = IDLE_OP;
    busy     = 1'b1;
    halted   = 1'b0;
    case (state_q)
      ST_IDLE:  busy = 1'b0;
      ST_FETCH: imem_req = 1'b1;
      ST_EXEC:  dpu_n = ir_n_q;
      ST_LOAD_WAIT: begin
        mem_req = 1'b1;
        dpu_n   = OP_LOAD;
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_addr      = pc_q;
  assign dpu_abus       = abus_q;
  assign dpu_bbus       = bbus_q;
  assign dpu_rbus       = rbus_q;
  assign dpu_out_enable = vid_q;

endmodule

// File: doc/dpu_sequencer.md
Name: dpu_sequencer

Overview:
- Microprogram sequencer for the CCU datapath unit.
- Fetches 16-bit microwords from an instruction memory and drives the DPU control buses (A/B/R register selects, opcode n).
- Handles memory-load handshakes (n=8), conditional branches on the DPU cc flags, and video-out strobes.
- Sits between the CCU top level, the instruction ROM and the DPU.

Parameters:
- PC_W, 8, program counter / instruction address width.
- ALU_CYCLES, 2, cycles n is held stable for an ALU op (min 1).
- IDLE_OP, 4'hE, opcode driven on dpu_n when no op is executing (non-writing).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin execution at current PC (level, sampled in IDLE).
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_valid  in  1  imem_data valid this cycle.
- imem_data  in  16  microword {n[15:12], a[11:8], b[7:4], r[3:0]}.
- mem_req  out  1  request the memory byte for an n=8 load.
- mem_ack  in  1  mData presented to the DPU is valid.
- dpu_abus  out  4  DPU A-register select.
- dpu_bbus  out  4  DPU B-register select.
- dpu_rbus  out  4  DPU result/destination register select.
- dpu_n  out  4  DPU opcode.
- dpu_cc  in  4  DPU condition codes.
- dpu_out_enable  out  1  video-out toggle to the DPU (toggles once per VID op).
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset values:
  - PC=RESET_PC, state IDLE.
  - imem_req=0, mem_req=0.
  - dpu_abus/bbus/rbus=0, dpu_n=IDLE_OP.
  - dpu_out_enable=0, busy=0, halted=0.
- Reset mid-operation: any state returns to IDLE immediately; outstanding fetch or load requests are dropped.
- Opcode classes:
  - n=0..7: ALU op.
  - n=8: LOAD.
  - n=9: BRcc; branch if dpu_cc[a[1:0]]==1 to {b,r} (zero-extended or truncated to PC_W).
  - n=10: JMP to {b,r}.
  - n=11: VID.
  - n=12/13: see Optional Feature.
  - n=14: NOP.
  - n=15: HALT.
- State machine:
  - IDLE: if start, go to FETCH.
  - FETCH: imem_req=1 and imem_addr=PC, held until imem_valid. On imem_valid, latch the word into IR, drop imem_req next cycle, go to DECODE.
  - DECODE (1 cycle): drive dpu_abus=a, dpu_bbus=b, dpu_rbus=r from IR; dpu_n stays IDLE_OP. Dispatch:
    - ALU → EXEC.
    - LOAD → LOAD_WAIT.
    - BRcc/JMP/NOP → FETCH (PC updated here).
    - VID → FETCH with dpu_out_enable toggled.
    - HALT → HALT.
  - EXEC: dpu_n=IR.n for exactly ALU_CYCLES cycles (internal counter), then dpu_n=IDLE_OP, PC+=1, go to FETCH.
  - LOAD_WAIT: dpu_n=8 and mem_req=1 until mem_ack. In the mem_ack cycle, hold dpu_n=8 for that cycle. Next cycle dpu_n=IDLE_OP, mem_req=0, PC+=1, go to FETCH.
  - HALT: stays until reset; start is ignored.
- PC arithmetic:
  - Modulo 2^PC_W; increment from all-ones wraps to 0.
  - Not-taken BRcc: PC+1.
  - cc is sampled in the DECODE cycle.
- A/B/R selects hold the last decoded values outside DECODE.
- imem_valid is ignored outside FETCH. mem_ack is ignored outside LOAD_WAIT.
- Minimum op latency, fetch to next fetch request, with imem_valid in the first fetch cycle:
  - ALU: 2+ALU_CYCLES+1 cycles.
  - Branch/jump/NOP/VID: 3 cycles.

Optional Feature:
- Macro: DPU_SEQ_CALL_RET_EN.
- Defined:
  - n=12 CALL: link register ← PC+1, PC ← {b,r}.
  - n=13 RET: PC ← link register.
  - Single level; a nested CALL overwrites the link register.
  - Link register resets to RESET_PC.
- Undefined: n=12/13 execute as NOP (PC+1) and no link register is synthesised.

Decomposition:
- Shared package dpu_pkg:
  - opcode constants (OP_LOAD=8, OP_BRCC, OP_JMP, OP_VID, OP_CALL, OP_RET, OP_NOP, OP_HALT).
  - state enum.
  - microword field positions.
- Sub-module: dpu_seq_decode — combinational opcode classifier: IR.n → is_alu/is_load/is_branch/... flags.
- PC, FSM and counter stay in dpu_sequencer.

Test Plan:
- Reset/idle: assert reset mid-EXEC → next cycle busy=0, dpu_n=4'hE, imem_req=0, PC=0. With start=0, no fetch ever issues.
- ALU op: word 16'h1235 at addr 0, imem_valid same cycle → DECODE drives A=2, B=3, R=5. dpu_n=1 for exactly 2 cycles, then 4'hE. Next imem_addr=1.
- Load: word 16'h8009 with mem_ack delayed 3 cycles → mem_req high 4 cycles, dpu_n=8 throughout, R=9. Next fetch at PC+1.
- Branch: 16'h9142 with cc=4'b0010 → next imem_addr=8'h42. Same word with cc=4'b0000 → PC+1. JMP 16'hA0FF → 8'hFF, then fall-through wraps to 0.
- Video/halt: 16'hB000 → dpu_out_enable toggles exactly once. Then 16'hF000 → halted=1, busy=0, no further imem_req even with start=1.
- With DPU_SEQ_CALL_RET_EN: CALL 16'hC020 at addr 5 → fetch 0x20. RET there → fetch 6. Without the macro, the same words advance PC by 1.
